// File: rtl/mem_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and data access.
// Data has fixed priority; a starvation counter forces a fetch grant after STARVE_LIMIT data wins.
module mem_arbiter #(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned STARVE_LIMIT = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_done,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_done,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam int unsigned      CNT_W = 4;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

    state_t             state_q, state_d;
    owner_t             owner_q, owner_d;
    logic [CNT_W-1:0]   starve_q, starve_d;
    logic               we_d;
    logic [ADDR_W-1:0]  addr_d;
    logic [DATA_W-1:0]  wdata_d;
    logic [DATA_W-1:0]  if_rdata_d, d_rdata_d;
    logic               mem_req_d, busy_d, if_done_d, d_done_d;

    // State, transaction latches and all outputs are flops cleared by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            owner_q   <= OWN_IF;
            starve_q  <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_rdata  <= '0;
            d_rdata   <= '0;
            if_done   <= 1'b0;
            d_done    <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            starve_q  <= starve_d;
            mem_req   <= mem_req_d;
            mem_we    <= we_d;
            mem_addr  <= addr_d;
            mem_wdata <= wdata_d;
            if_rdata  <= if_rdata_d;
            d_rdata   <= d_rdata_d;
            if_done   <= if_done_d;
            d_done    <= d_done_d;
            busy      <= busy_d;
        end
    end

    // Next state, arbitration and next-cycle output values.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        starve_d   = starve_q;
        we_d       = mem_we;
        addr_d     = mem_addr;
        wdata_d    = mem_wdata;
        if_rdata_d = if_rdata;
        d_rdata_d  = d_rdata;

        unique case (state_q)
            S_IDLE: begin
                if (d_req && !(if_req && (starve_q == LIMIT))) begin
                    state_d = S_REQ;
                    owner_d = OWN_D;
                    we_d    = d_we;
                    addr_d  = d_addr;
                    wdata_d = d_wdata;
                    if (if_req && (starve_q != LIMIT)) begin
                        starve_d = starve_q + CNT_W'(1);
                    end
                end else if (if_req) begin
                    state_d  = S_REQ;
                    owner_d  = OWN_IF;
                    we_d     = 1'b0;
                    addr_d   = if_addr;
                    wdata_d  = '0;
                    starve_d = '0;
                end
            end
            S_REQ: begin
                if (mem_ready) begin
                    state_d = mem_we ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem_rvalid) begin
                    state_d = S_RESP;
                    if (owner_q == OWN_D) begin
                        d_rdata_d = mem_rdata;
                    end else begin
                        if_rdata_d = mem_rdata;
                    end
                end
            end
            S_RESP: begin
                // Bubble back to IDLE so a still-high request is not re-granted for the same transfer.
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        mem_req_d = (state_d == S_REQ);
        busy_d    = (state_d != S_IDLE);
        if_done_d = (state_d == S_RESP) && (owner_d == OWN_IF);
        d_done_d  = (state_d == S_RESP) && (owner_d == OWN_D);
    end

endmodule
